// File: rtl/axis_bridge_pkg.sv
// Shared state encoding and length helpers for the AXI-Stream frame bridge.
package axis_bridge_pkg;

    localparam int STATEBITS = 3;

    typedef enum logic [STATEBITS-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SLAVE  = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_MASTER = 3'd5
    } state_t;

    // Zero or oversize requests mean "use the whole buffer".
    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned depth
    );
        return (len == 0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/axis_bridge_buf.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module axis_bridge_buf
    import axis_bridge_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 1024,
    localparam int ADRWIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [ADRWIDTH-1:0]  wr_adr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [ADRWIDTH-1:0]  rd_adr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_adr] <= wr_data;
        end
    end

    // Only the read register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_adr];
        end
    end

endmodule

// File: rtl/axis_frame_bridge.sv
// AXI-Stream <-> accelerator frame bridge with length checking and status.
// Optional AXIS_BRIDGE_ERR_CNT_EN adds a saturating erroneous-frame counter.
module axis_frame_bridge
    import axis_bridge_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int INPDEPTH     = 1024,
    parameter int OUTDEPTH     = 16,
    localparam int INPADRWIDTH = $clog2(INPDEPTH),
    localparam int OUTADRWIDTH = $clog2(OUTDEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_start,
    output logic                   ex_startAck,
    input  logic [INPADRWIDTH:0]   cfg_inp_len,
    input  logic [OUTADRWIDTH:0]   cfg_out_len,
    input  logic [DATAWIDTH-1:0]   s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [DATAWIDTH-1:0]   m_data,
    output logic                   m_valid,
    output logic                   m_last,
    input  logic                   m_ready,
    output logic                   waitSt,
    input  logic                   waitFin,
    input  logic [INPADRWIDTH-1:0] inp_adr,
    output logic [DATAWIDTH-1:0]   inp_data,
    output logic [OUTADRWIDTH-1:0] out_adr,
    input  logic [DATAWIDTH-1:0]   out_data,
    output logic                   busy,
    output logic                   err_early,
    output logic                   err_late
`ifdef AXIS_BRIDGE_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);

    localparam int IL = INPADRWIDTH + 1;
    localparam int OL = OUTADRWIDTH + 1;

    state_t        state;
    state_t        state_nxt;
    logic [IL-1:0] inp_len;
    logic [OL-1:0] out_len;
    logic [IL-1:0] ict;
    logic [OL-1:0] oct;
    logic          beat_final;
    logic          out_final;
    logic          wr_en;

    assign beat_final = (ict == inp_len - IL'(1));
    assign out_final  = (oct == out_len - OL'(1));
    assign wr_en      = (state == ST_SLAVE) && s_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (ex_start) state_nxt = ST_START;
            end
            ST_START: begin
                if (!ex_start) state_nxt = ST_SLAVE;
            end
            ST_SLAVE: begin
                if (s_valid) begin
                    if (beat_final) begin
                        state_nxt = s_last ? ST_WAIT : ST_DRAIN;
                    end else if (s_last) begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_DRAIN: begin
                if (s_valid && s_last) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (waitFin) state_nxt = ST_MASTER;
            end
            ST_MASTER: begin
                if (m_ready && out_final) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ex_startAck = 1'b0;
        s_ready     = 1'b0;
        waitSt      = 1'b0;
        m_valid     = 1'b0;
        busy        = (state != ST_IDLE);
        unique case (state)
            ST_START:  ex_startAck = 1'b1;
            ST_SLAVE:  s_ready     = 1'b1;
            ST_DRAIN:  s_ready     = 1'b1;
            ST_WAIT:   waitSt      = 1'b1;
            ST_MASTER: m_valid     = 1'b1;
            default:   ;
        endcase
    end

    // out_data depends only on out_adr, so holding oct holds m_data.
    assign out_adr = oct[OUTADRWIDTH-1:0];
    assign m_data  = m_valid ? out_data : '0;
    assign m_last  = m_valid && out_final;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inp_len   <= '0;
            out_len   <= '0;
            ict       <= '0;
            oct       <= '0;
            err_early <= 1'b0;
            err_late  <= 1'b0;
        end else begin
            if (state == ST_IDLE && ex_start) begin
                inp_len   <= IL'(clamp_len(32'(cfg_inp_len), INPDEPTH));
                out_len   <= OL'(clamp_len(32'(cfg_out_len), OUTDEPTH));
                ict       <= '0;
                oct       <= '0;
                err_early <= 1'b0;
                err_late  <= 1'b0;
            end
            if (wr_en) begin
                ict <= ict + IL'(1);
                if (beat_final && !s_last) err_late <= 1'b1;
                if (!beat_final && s_last) err_early <= 1'b1;
            end
            if (state == ST_MASTER && m_ready) begin
                oct <= out_final ? '0 : oct + OL'(1);
            end
        end
    end

`ifdef AXIS_BRIDGE_ERR_CNT_EN
    logic err_inc;

    // Both error exits into WAIT; each frame reaches WAIT exactly once.
    assign err_inc = (wr_en && s_last && !beat_final) ||
                     (state == ST_DRAIN && s_valid && s_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_inc && err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

    axis_bridge_buf #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (INPDEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_adr  (ict[INPADRWIDTH-1:0]),
        .wr_data (s_data),
        .rd_adr  (inp_adr),
        .rd_data (inp_data)
    );

endmodule

// File: tb/tb_axis_frame_bridge.sv
// Randomised self-checking bench for axis_frame_bridge (16-word buffers).
module tb_axis_frame_bridge;

    localparam int DW  = 32;
    localparam int ID  = 16;
    localparam int OD  = 16;
    localparam int IAW = $clog2(ID);
    localparam int OAW = $clog2(OD);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ex_start = 1'b0;
    logic           ex_startAck;
    logic [IAW:0]   cfg_inp_len = '0;
    logic [OAW:0]   cfg_out_len = '0;
    logic [DW-1:0]  s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [DW-1:0]  m_data;
    logic           m_valid;
    logic           m_last;
    logic           m_ready = 1'b0;
    logic           waitSt;
    logic           waitFin = 1'b0;
    logic [IAW-1:0] inp_adr = '0;
    logic [DW-1:0]  inp_data;
    logic [OAW-1:0] out_adr;
    logic [DW-1:0]  out_data;
    logic           busy;
    logic           err_early;
    logic           err_late;
`ifdef AXIS_BRIDGE_ERR_CNT_EN
    logic [15:0]    err_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference state: expected buffer contents and erroneous-frame count
    logic [DW-1:0] mbuf [ID];
    bit            mknown [ID];
    int            ecnt = 0;
    logic [DW-1:0] key = '0;

    always #5 clk = ~clk;

    // compute-unit stub: result word = key + 2*address
    always_comb out_data = key + 32'(out_adr) * 32'd2;

    axis_frame_bridge #(
        .DATAWIDTH (DW),
        .INPDEPTH  (ID),
        .OUTDEPTH  (OD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_start    (ex_start),
        .ex_startAck (ex_startAck),
        .cfg_inp_len (cfg_inp_len),
        .cfg_out_len (cfg_out_len),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .waitSt      (waitSt),
        .waitFin     (waitFin),
        .inp_adr     (inp_adr),
        .inp_data    (inp_data),
        .out_adr     (out_adr),
        .out_data    (out_data),
        .busy        (busy),
        .err_early   (err_early),
`ifdef AXIS_BRIDGE_ERR_CNT_EN
        .err_late    (err_late),
        .err_cnt     (err_cnt)
`else
        .err_late    (err_late)
`endif
    );

    // Full frame: start, send beats 0..last_idx, read back buffer, emit result.
    // mode: 0 = always ready, 1 = 1010 ready toggle, 2 = random valid/ready
    task automatic run_frame(
        input string nm,
        input int    ilen_cfg,
        input int    olen_cfg,
        input int    last_idx,
        input int    mode
    );
        logic [DW-1:0] d [64];
        int  ilen, olen, i, k, cyc;
        bit  exp_early, exp_late, sr, mv;

        ilen = (ilen_cfg == 0 || ilen_cfg > ID) ? ID : ilen_cfg;
        olen = (olen_cfg == 0 || olen_cfg > OD) ? OD : olen_cfg;
        key  = (mode == 2) ? DW'($urandom) : '0;
        for (int j = 0; j <= last_idx; j++) begin
            d[j] = (mode == 2) ? DW'($urandom) : DW'(j);
        end
        exp_early = last_idx < ilen - 1;
        exp_late  = last_idx > ilen - 1;
        for (int j = 0; j <= last_idx && j < ilen; j++) begin
            mbuf[j]   = d[j];
            mknown[j] = 1'b1;
        end
        if (exp_early || exp_late) ecnt++;

        cfg_inp_len = (IAW+1)'(ilen_cfg);
        cfg_out_len = (OAW+1)'(olen_cfg);
        ex_start    = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!ex_startAck && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (ex_startAck !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s start_ack: ack=%b busy=%b want 1 1",
                     nm, ex_startAck, busy);
        end
        ex_start = 1'b0;

        i = 0;
        cyc = 0;
        while (i <= last_idx && cyc < 1000) begin
            s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = d[i];
            s_last  = (i == last_idx);
            sr = s_ready;
            @(posedge clk);
            if (sr && s_valid) i++;
            @(negedge clk);
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n_cmp++;
        if (i != last_idx + 1) begin
            n_err++;
            $display("FAIL %s beats: accepted %0d want %0d",
                     nm, i, last_idx + 1);
        end

        n_cmp++;
        if (waitSt !== 1'b1) begin
            n_err++;
            $display("FAIL %s wait_entry: waitSt=%b want 1", nm, waitSt);
        end
        n_cmp++;
        if (err_early !== exp_early || err_late !== exp_late) begin
            n_err++;
            $display("FAIL %s err_flags: early=%b late=%b want %b %b",
                     nm, err_early, err_late, exp_early, exp_late);
        end
`ifdef AXIS_BRIDGE_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 16'(ecnt)) begin
            n_err++;
            $display("FAIL %s err_cnt: got %0d want %0d", nm, err_cnt, ecnt);
        end
`endif

        for (int a = 0; a < ID; a++) begin
            if (mknown[a]) begin
                inp_adr = IAW'(a);
                @(negedge clk);
                n_cmp++;
                if (inp_data !== mbuf[a]) begin
                    n_err++;
                    $display("FAIL %s buf[%0d]: got %h want %h",
                             nm, a, inp_data, mbuf[a]);
                end
            end
        end

        // a start request while busy must be ignored
        ex_start = 1'b1;
        @(negedge clk);
        ex_start = 1'b0;
        n_cmp++;
        if (waitSt !== 1'b1 || ex_startAck !== 1'b0) begin
            n_err++;
            $display("FAIL %s start_ignored: waitSt=%b ack=%b want 1 0",
                     nm, waitSt, ex_startAck);
        end

        waitFin = 1'b1;
        @(negedge clk);
        waitFin = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s master_entry: m_valid=%b want 1", nm, m_valid);
        end

        k = 0;
        cyc = 0;
        while (busy && cyc < 500) begin
            if (m_valid) begin
                n_cmp++;
                if (m_data !== key + DW'(k) * 32'd2 || m_last !== (k == olen - 1)) begin
                    n_err++;
                    $display("FAIL %s word%0d: data=%h last=%b want %h %b",
                             nm, k, m_data, m_last,
                             key + DW'(k) * 32'd2, (k == olen - 1));
                end
            end
            if (mode == 1)      m_ready = (cyc % 2 == 0);
            else if (mode == 2) m_ready = ($urandom_range(0, 1) == 1);
            else                m_ready = 1'b1;
            mv = m_valid;
            @(posedge clk);
            if (mv && m_ready) k++;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        n_cmp++;
        if (k != olen || busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s transfers: got %0d busy=%b want %0d busy=0",
                     nm, k, busy, olen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ex_startAck, s_ready, m_valid, m_last, waitSt, busy,
             err_early, err_late} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ack=%b srdy=%b mv=%b ml=%b ws=%b bsy=%b ee=%b el=%b want 0",
                     ex_startAck, s_ready, m_valid, m_last, waitSt, busy,
                     err_early, err_late);
        end
        n_cmp++;
        if (m_data !== '0 || inp_data !== '0 || out_adr !== '0) begin
            n_err++;
            $display("FAIL reset_data: m_data=%h inp_data=%h out_adr=%h want 0",
                     m_data, inp_data, out_adr);
        end
`ifdef AXIS_BRIDGE_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        ecnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        run_frame("nominal", 8, 4, 7, 0);
    endtask

    task automatic test_backpressure();
        run_frame("backpressure", 8, 4, 7, 1);
    endtask

    task automatic test_early_last();
        run_frame("early_last", 8, 4, 4, 0);
    endtask

    task automatic test_late_last();
        run_frame("late_last", 4, 4, 5, 0);
    endtask

    task automatic test_clamp();
        run_frame("clamp", 0, 0, 15, 0);
    endtask

    task automatic test_mid_reset();
        int cyc;
        cfg_inp_len = 5'd8;
        cfg_out_len = 5'd4;
        ex_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ex_start = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            s_data    = 32'hA000 + DW'(j);
            mbuf[j]   = s_data;
            mknown[j] = 1'b1;
            @(negedge clk);
        end
        mknown[3] = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        n_cmp++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || err_early !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: s_ready=%b busy=%b ee=%b want 0 0 0",
                     s_ready, busy, err_early);
        end
        ecnt = 0;
        rst_n = 1'b1;
        cyc = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid || waitSt || busy) cyc++;
        end
        n_cmp++;
        if (cyc != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: active cycles %0d want 0", cyc);
        end
        run_frame("after_reset", 8, 4, 7, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            run_frame("random", $urandom_range(0, 20), $urandom_range(0, 18),
                      $urandom_range(0, 19), 2);
        end
    endtask

    initial begin
        for (int a = 0; a < ID; a++) begin
            mknown[a] = 1'b0;
            mbuf[a]   = '0;
        end
        test_reset();
        test_nominal();
        test_backpressure();
        test_early_last();
        test_late_last();
        test_clamp();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
